// File: rtl/equilibrium_maxxing_uc_if.sv
// Status/control bundle between the Equilibrium Maxxing control unit and its datapath.
// master = control unit, slave = datapath side (or bench).
interface equilibrium_maxxing_uc_if;
   logic       iniciar;
   logic       sensorFimCurso;
   logic       prep_done;
   logic       ganhou_ponto;
   logic       perdeu_ponto;
   logic [7:0] pontuacao;
   logic       calib_start;
   logic       trava_servo;
   logic       reset_prep_cnt;
   logic       reset_nivel_locked;
   logic       start_game;
   logic       reset_nivel;
   logic       gerar_nova_jogada;
   logic       fade_trigger;
   logic       conta_nivel;
   logic       pronto;
   logic       venceu;
   logic       erro_calib;
   logic [3:0] db_estado;

   modport master (
      input  iniciar, sensorFimCurso, prep_done, ganhou_ponto, perdeu_ponto, pontuacao,
      output calib_start, trava_servo, reset_prep_cnt, reset_nivel_locked, start_game,
             reset_nivel, gerar_nova_jogada, fade_trigger, conta_nivel, pronto, venceu,
             erro_calib, db_estado
   );

   modport slave (
      output iniciar, sensorFimCurso, prep_done, ganhou_ponto, perdeu_ponto, pontuacao,
      input  calib_start, trava_servo, reset_prep_cnt, reset_nivel_locked, start_game,
             reset_nivel, gerar_nova_jogada, fade_trigger, conta_nivel, pronto, venceu,
             erro_calib, db_estado
   );
endinterface

// File: rtl/equilibrium_maxxing_uc.sv
// Moore control FSM for the Equilibrium Maxxing game: calibration, level select,
// round sequencing, scoring and level progression, with saturating tick/score counters.
module equilibrium_maxxing_uc #(
   parameter int PONTOS_VITORIA   = 20,
   parameter int ERROS_MAX        = 3,
   parameter int PONTOS_POR_NIVEL = 5,
   parameter int PREP_TICKS       = 5,
   parameter int CALIB_TIMEOUT    = 50
) (
   input  logic clock,
   input  logic reset,
   equilibrium_maxxing_uc_if.master bus
);
   localparam logic [7:0] VIT_LIM   = 8'(PONTOS_VITORIA);
   localparam logic [3:0] ERR_LIM   = 4'(ERROS_MAX);
   localparam logic [3:0] NIVEL_LIM = 4'(PONTOS_POR_NIVEL);
   localparam logic [7:0] PREP_LIM  = 8'(PREP_TICKS);
   localparam logic [7:0] CALIB_LIM = 8'(CALIB_TIMEOUT);

   typedef enum logic [3:0] {
      INICIAL      = 4'h0,
      CALIBRA      = 4'h1,
      ESPERA_CALIB = 4'h2,
      SELECIONA    = 4'h3,
      TRAVA        = 4'h4,
      PREPARA      = 4'h5,
      GERA         = 4'h6,
      FADE         = 4'h7,
      JOGANDO      = 4'h8,
      AVALIA       = 4'h9,
      SOBE_NIVEL   = 4'hA,
      VITORIA      = 4'hB,
      DERROTA      = 4'hC,
      ERRO         = 4'hE
   } state_t;

   state_t     state, next_state;
   logic       iniciar_d;
   logic       ini_edge;
   logic [7:0] tick_cnt;
   logic [3:0] erros, acertos;

   // iniciar_d resets high so a button held through reset is not seen as a press
   assign ini_edge = bus.iniciar & ~iniciar_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= INICIAL;
         iniciar_d <= 1'b1;
         tick_cnt  <= '0;
         erros     <= '0;
         acertos   <= '0;
      end else begin
         state     <= next_state;
         iniciar_d <= bus.iniciar;
         case (state)
            CALIBRA: tick_cnt <= '0;
            ESPERA_CALIB:
               if (bus.prep_done && tick_cnt != 8'hFF) tick_cnt <= tick_cnt + 8'd1;
            TRAVA: begin
               tick_cnt <= '0;
               erros    <= '0;
               acertos  <= '0;
            end
            // a tick landing on the exit cycle is dropped rather than carried forward
            PREPARA:
               if (bus.prep_done && tick_cnt != PREP_LIM && tick_cnt != 8'hFF)
                  tick_cnt <= tick_cnt + 8'd1;
            JOGANDO:
               if (bus.ganhou_ponto) begin
                  if (acertos != 4'hF) acertos <= acertos + 4'd1;
               end else if (bus.perdeu_ponto) begin
                  if (erros != 4'hF) erros <= erros + 4'd1;
                  acertos <= '0;
               end
            SOBE_NIVEL: begin
               acertos  <= '0;
               tick_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      next_state            = state;
      bus.calib_start        = 1'b0;
      bus.trava_servo        = 1'b0;
      bus.reset_prep_cnt     = 1'b0;
      bus.reset_nivel_locked = 1'b0;
      bus.start_game         = 1'b0;
      bus.reset_nivel        = 1'b0;
      bus.gerar_nova_jogada  = 1'b0;
      bus.fade_trigger       = 1'b0;
      bus.conta_nivel        = 1'b0;
      bus.pronto             = 1'b0;
      bus.venceu             = 1'b0;
      bus.erro_calib         = 1'b0;
      case (state)
         INICIAL: begin
            bus.trava_servo        = 1'b1;
            bus.reset_nivel_locked = 1'b1;
            if (ini_edge) next_state = CALIBRA;
         end
         CALIBRA: begin
            bus.calib_start    = 1'b1;
            bus.reset_prep_cnt = 1'b1;
            next_state         = ESPERA_CALIB;
         end
         ESPERA_CALIB: begin
            bus.calib_start = 1'b1;
            if (bus.sensorFimCurso)       next_state = SELECIONA;
            else if (tick_cnt == CALIB_LIM) next_state = ERRO;
         end
         SELECIONA: begin
            bus.trava_servo = 1'b1;
            if (ini_edge) next_state = TRAVA;
         end
         TRAVA: begin
            bus.start_game     = 1'b1;
            bus.reset_nivel    = 1'b1;
            bus.reset_prep_cnt = 1'b1;
            bus.trava_servo    = 1'b1;
            next_state         = PREPARA;
         end
         PREPARA: if (tick_cnt == PREP_LIM) next_state = GERA;
         GERA: begin
            bus.gerar_nova_jogada = 1'b1;
            next_state            = FADE;
         end
         FADE: begin
            bus.fade_trigger   = 1'b1;
            bus.reset_prep_cnt = 1'b1;
            next_state         = JOGANDO;
         end
         JOGANDO: if (bus.ganhou_ponto || bus.perdeu_ponto) next_state = AVALIA;
         AVALIA: begin
            if (bus.pontuacao >= VIT_LIM)  next_state = VITORIA;
            else if (erros == ERR_LIM)     next_state = DERROTA;
            else if (acertos == NIVEL_LIM) next_state = SOBE_NIVEL;
            else                           next_state = GERA;
         end
         SOBE_NIVEL: begin
            bus.conta_nivel    = 1'b1;
            bus.reset_prep_cnt = 1'b1;
            next_state         = PREPARA;
         end
         VITORIA, DERROTA: begin
            bus.pronto      = 1'b1;
            bus.venceu      = (state == VITORIA);
            bus.trava_servo = 1'b1;
            if (ini_edge) next_state = SELECIONA;
         end
         ERRO: begin
            bus.erro_calib         = 1'b1;
            bus.trava_servo        = 1'b1;
            bus.reset_nivel_locked = 1'b1;
            if (ini_edge) next_state = CALIBRA;
         end
         default: next_state = INICIAL;
      endcase
   end

   assign bus.db_estado = state;
endmodule

// File: tb/tb_equilibrium_maxxing_uc.sv
// Scoreboard bench for equilibrium_maxxing_uc: each driven cycle queues the expected
// state, a monitor pops it after the edge and checks state code plus all control outputs.
module tb_equilibrium_maxxing_uc;
   logic clock = 1'b0;
   logic reset = 1'b0;
   equilibrium_maxxing_uc_if bus();

   equilibrium_maxxing_uc dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   int         checks = 0;
   int         errors = 0;
   int         step   = 0;
   logic [3:0] exp_q[$];
   logic [3:0] mon_e;
   logic       ini = 1'b0, sen = 1'b0;
   logic [7:0] pts = 8'd0;
   logic [11:0] outs;

   assign outs = {bus.calib_start, bus.trava_servo, bus.reset_prep_cnt, bus.reset_nivel_locked,
                  bus.start_game, bus.reset_nivel, bus.gerar_nova_jogada, bus.fade_trigger,
                  bus.conta_nivel, bus.pronto, bus.venceu, bus.erro_calib};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h want %0h", tag, step, obs, exp);
      end
   endtask

   // {calib,trava,rprep,rnl,start,rniv,gera,fade,conta,pronto,venceu,erro}
   function automatic logic [11:0] exp_out(input logic [3:0] s);
      case (s)
         4'h0:    return 12'b0101_0000_0000;
         4'h1:    return 12'b1010_0000_0000;
         4'h2:    return 12'b1000_0000_0000;
         4'h3:    return 12'b0100_0000_0000;
         4'h4:    return 12'b0110_1100_0000;
         4'h6:    return 12'b0000_0010_0000;
         4'h7:    return 12'b0010_0001_0000;
         4'hA:    return 12'b0010_0000_1000;
         4'hB:    return 12'b0100_0000_0110;
         4'hC:    return 12'b0100_0000_0100;
         4'hE:    return 12'b0101_0000_0001;
         default: return 12'b0000_0000_0000;
      endcase
   endfunction

   always @(posedge clock) begin
      #2;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("state", 32'(bus.db_estado), 32'(mon_e));
         chk("outs", 32'(outs), 32'(exp_out(mon_e)));
      end
   end

   // one cycle: drive inputs, queue the state expected after the next edge
   task automatic t(input logic [3:0] es, input logic pd = 1'b0, input logic gh = 1'b0,
                    input logic pp = 1'b0);
      bus.iniciar        = ini;
      bus.sensorFimCurso = sen;
      bus.prep_done      = pd;
      bus.ganhou_ponto   = gh;
      bus.perdeu_ponto   = pp;
      bus.pontuacao      = pts;
      exp_q.push_back(es);
      step++;
      @(posedge clock);
      #1;
   endtask

   task automatic to_jogando;
      ini = 1'b1; t(4'h4);
      ini = 1'b0; t(4'h5);
      repeat (5) t(4'h5, 1'b1);
      t(4'h6, 1'b1);
      t(4'h7);
      t(4'h8);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.iniciar = 1'b0; bus.sensorFimCurso = 1'b0; bus.prep_done = 1'b0;
      bus.ganhou_ponto = 1'b0; bus.perdeu_ponto = 1'b0; bus.pontuacao = 8'd0;
      #1;
      // reset with button held, release: no edge
      reset = 1'b0; ini = 1'b1;
      t(4'h0); t(4'h0);
      reset = 1'b1;
      t(4'h0); t(4'h0);
      ini = 1'b0; t(4'h0);
      // calibration timeout
      ini = 1'b1; t(4'h1);
      ini = 1'b0; t(4'h2);
      repeat (50) t(4'h2, 1'b1);
      t(4'hE);
      t(4'hE);
      // recalibrate, sensor after 3 ticks
      ini = 1'b1; t(4'h1);
      ini = 1'b0; t(4'h2);
      repeat (3) t(4'h2, 1'b1);
      sen = 1'b1; t(4'h3);
      sen = 1'b0; t(4'h3);
      to_jogando();
      t(4'h8);
      // five hits, the third with a simultaneous miss
      for (int i = 1; i <= 5; i++) begin
         pts = 8'(i);
         t(4'h9, 1'b0, 1'b1, (i == 3));
         if (i == 3) chk("erros_sim", 32'(dut.erros), 32'd0);
         if (i < 5) begin
            t(4'h6); t(4'h7); t(4'h8);
         end else begin
            t(4'hA); t(4'h5);
         end
      end
      repeat (5) t(4'h5, 1'b1);
      t(4'h6); t(4'h7); t(4'h8);
      // three misses -> loss
      for (int k = 1; k <= 3; k++) begin
         t(4'h9, 1'b0, 1'b0, 1'b1);
         if (k < 3) begin
            t(4'h6); t(4'h7); t(4'h8);
         end else begin
            t(4'hC);
         end
      end
      t(4'hC);
      ini = 1'b1; t(4'h3);
      ini = 1'b0; t(4'h3);
      to_jogando();
      // winning hit
      pts = 8'd20;
      t(4'h9, 1'b0, 1'b1);
      t(4'hB); t(4'hB);
      ini = 1'b1; t(4'h3);
      ini = 1'b0; t(4'h3);
      // reset in the middle of a game
      pts = 8'd0;
      to_jogando();
      t(4'h9, 1'b0, 1'b0, 1'b1);
      t(4'h6); t(4'h7); t(4'h8);
      reset = 1'b0;
      t(4'h0, 1'b0, 1'b1);
      chk("rst_erros", 32'(dut.erros), 32'd0);
      chk("rst_acertos", 32'(dut.acertos), 32'd0);
      chk("rst_tick", 32'(dut.tick_cnt), 32'd0);
      reset = 1'b1;
      t(4'h0);
      repeat (3) @(posedge clock);
      #3;
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
